// File: rtl/fibonacci_checker.sv
// Fibonacci stream self-check monitor: verifies each accepted term is the modulo-2^W sum of the previous two.
// Optional FIB_CHECK_DOUBLE_RATE_EN adds in_num2 and checks two terms per beat.
module fibonacci_checker #(
  parameter int W          = 16,
  parameter int SEED_CHECK = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_num,
`ifdef FIB_CHECK_DOUBLE_RATE_EN
  input  logic [W-1:0]     in_num2,
`endif
  output logic             match,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] cnt,
  output logic [W-1:0]     expected
);

  typedef enum logic [1:0] {S_FIRST, S_SECOND, S_CHECK, S_FAIL} state_t;

  localparam logic [W-1:0] ONE = W'(1);
`ifdef FIB_CHECK_DOUBLE_RATE_EN
  localparam logic [1:0] INC = 2'd2;
`else
  localparam logic [1:0] INC = 2'd1;
`endif

  state_t           state_reg, state_next;
  logic [W-1:0]     prev_reg, prev_next;
  logic [W-1:0]     cur_reg, cur_next;
  logic [W-1:0]     exp_reg, exp_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             match_reg, match_next;
  logic             mismatch_reg, mismatch_next;
  logic             accept;
  logic             beat_ok;
  logic [W-1:0]     step_sum;
`ifdef FIB_CHECK_DOUBLE_RATE_EN
  logic [W-1:0]     pair_sum;
`endif

  function automatic logic seed_ok(input logic [W-1:0] v);
    return (SEED_CHECK == 0) || (v == ONE);
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign in_ready = (state_reg != S_FAIL);
  assign accept   = in_valid && in_ready;
  assign step_sum = cur_reg + in_num;
`ifdef FIB_CHECK_DOUBLE_RATE_EN
  assign pair_sum = in_num + in_num2;
`endif

  always_comb begin
    state_next    = state_reg;
    prev_next     = prev_reg;
    cur_next      = cur_reg;
    exp_next      = exp_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    match_next    = 1'b0;
    mismatch_next = 1'b0;
    beat_ok       = 1'b0;
    if (clr) begin
      state_next = S_FIRST;
      prev_next  = '0;
      cur_next   = '0;
      exp_next   = '0;
      cnt_next   = '0;
      err_next   = 1'b0;
    end else if (accept) begin
      unique case (state_reg)
`ifdef FIB_CHECK_DOUBLE_RATE_EN
        S_FIRST: begin
          beat_ok = seed_ok(in_num) && seed_ok(in_num2);
          if (beat_ok) begin
            prev_next  = in_num;
            cur_next   = in_num2;
            exp_next   = pair_sum;
            state_next = S_CHECK;
          end
        end
        S_SECOND: begin
          beat_ok = seed_ok(in_num) && (in_num2 == step_sum);
          if (beat_ok) begin
            prev_next  = in_num;
            cur_next   = in_num2;
            exp_next   = pair_sum;
            state_next = S_CHECK;
          end
        end
        S_CHECK: begin
          beat_ok = (in_num == exp_reg) && (in_num2 == step_sum);
          if (beat_ok) begin
            prev_next = in_num;
            cur_next  = in_num2;
            exp_next  = pair_sum;
          end
        end
`else
        S_FIRST: begin
          cur_next   = in_num;
          beat_ok    = seed_ok(in_num);
          state_next = S_SECOND;
        end
        S_SECOND: begin
          prev_next  = cur_reg;
          cur_next   = in_num;
          exp_next   = step_sum;
          beat_ok    = seed_ok(in_num);
          state_next = S_CHECK;
        end
        S_CHECK: begin
          beat_ok = (in_num == exp_reg);
          if (beat_ok) begin
            prev_next = cur_reg;
            cur_next  = in_num;
            exp_next  = step_sum;
          end
        end
`endif
        default: beat_ok = 1'b0;
      endcase
      // A failing beat overrides any state advance chosen above.
      if (beat_ok) begin
        match_next = 1'b1;
        cnt_next   = sat_add(cnt_reg, INC);
      end else begin
        mismatch_next = 1'b1;
        err_next      = 1'b1;
        state_next    = S_FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_FIRST;
      prev_reg     <= '0;
      cur_reg      <= '0;
      exp_reg      <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      match_reg    <= 1'b0;
      mismatch_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      prev_reg     <= prev_next;
      cur_reg      <= cur_next;
      exp_reg      <= exp_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      match_reg    <= match_next;
      mismatch_reg <= mismatch_next;
    end
  end

  assign match    = match_reg;
  assign mismatch = mismatch_reg;
  assign err      = err_reg;
  assign cnt      = cnt_reg;
  assign expected = exp_reg;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker: a reference model queues the expected outcome of each beat,
// a negedge monitor pops and compares it the cycle after the handshake.
module tb_fibonacci_checker;
  localparam int W      = 16;
  localparam int CNT_W  = 16;
  localparam int CNT0_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_num = '0;
  logic             in_ready, match, mismatch, err;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     expected;

  logic              clr0 = 1'b0;
  logic              in_valid0 = 1'b0;
  logic [W-1:0]      in_num0 = '0;
  logic              in_ready0, match0, mismatch0, err0;
  logic [CNT0_W-1:0] cnt0;
  logic [W-1:0]      expected0;
`ifdef FIB_CHECK_DOUBLE_RATE_EN
  logic [W-1:0]      in_num2 = '0;
  logic [W-1:0]      in_num20 = '0;
`endif

  fibonacci_checker #(.W(W), .SEED_CHECK(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
`ifdef FIB_CHECK_DOUBLE_RATE_EN
    .in_num2(in_num2),
`endif
    .match(match), .mismatch(mismatch), .err(err), .cnt(cnt), .expected(expected)
  );

  fibonacci_checker #(.W(W), .SEED_CHECK(0), .CNT_W(CNT0_W)) dut0 (
    .clk(clk), .rst(rst), .clr(clr0), .in_valid(in_valid0), .in_ready(in_ready0), .in_num(in_num0),
`ifdef FIB_CHECK_DOUBLE_RATE_EN
    .in_num2(in_num20),
`endif
    .match(match0), .mismatch(mismatch0), .err(err0), .cnt(cnt0), .expected(expected0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  typedef struct {
    logic             m;
    logic             mm;
    logic             e;
    logic [CNT_W-1:0] c;
    logic [W-1:0]     x;
  } res_t;
  res_t sb_q[$];

  // Reference model: 0=first seed, 1=second seed, 2=checking, 3=failed
  int               m_state;
  logic [W-1:0]     m_prev, m_cur, m_exp;
  logic [CNT_W-1:0] m_cnt;
  logic             m_err;

  task automatic model_reset();
    m_state = 0; m_prev = '0; m_cur = '0; m_exp = '0; m_cnt = '0; m_err = 1'b0;
  endtask

  task automatic model_push(input logic ok, input int inc);
    res_t r;
    if (ok) begin
      for (int i = 0; i < inc; i++) if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end else begin
      m_err = 1'b1;
      m_state = 3;
    end
    r.m = ok; r.mm = !ok; r.e = m_err; r.c = m_cnt; r.x = m_exp;
    sb_q.push_back(r);
  endtask

`ifndef FIB_CHECK_DOUBLE_RATE_EN
  task automatic model_beat(input logic [W-1:0] n);
    logic         ok;
    logic [W-1:0] fib;
    ok = 1'b0;
    fib = m_prev + m_cur;
    case (m_state)
      0: begin m_cur = n; ok = (n == 1); if (ok) m_state = 1; end
      1: begin
        m_prev = m_cur; m_cur = n; m_exp = m_prev + m_cur;
        ok = (n == 1);
        if (ok) m_state = 2;
      end
      2: begin
        ok = (n == fib);
        if (ok) begin m_prev = m_cur; m_cur = n; m_exp = m_prev + m_cur; end
      end
      default: ok = 1'b0;
    endcase
    model_push(ok, 1);
  endtask

  task automatic send(input logic [W-1:0] n);
    @(negedge clk);
    in_valid = 1'b1;
    in_num = n;
    model_beat(n);
    @(posedge clk);
  endtask

  task automatic send0(input logic [W-1:0] n);
    @(negedge clk);
    in_valid0 = 1'b1;
    in_num0 = n;
    @(posedge clk);
    #1;
  endtask
`else
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    logic         ok;
    logic [W-1:0] fa, fb;
    @(negedge clk);
    in_valid = 1'b1;
    in_num = a;
    in_num2 = b;
    fa = m_prev + m_cur;
    fb = m_cur + a;
    ok = 1'b0;
    if (m_state == 0) ok = (a == 1) && (b == 1);
    else if (m_state == 2) ok = (a == fa) && (b == fb);
    if (ok) begin m_prev = a; m_cur = b; m_exp = a + b; m_state = 2; end
    model_push(ok, 2);
    @(posedge clk);
  endtask
`endif

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
  endtask

  // Monitor: a handshake at a posedge is judged at the following negedge.
  logic hs = 1'b0;
  always @(posedge clk) hs <= in_valid && in_ready && !clr && rst;

  always @(negedge clk) begin
    res_t r;
    if (hs) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        r = sb_q.pop_front();
        check_val("match", 32'(match), 32'(r.m));
        check_val("mismatch", 32'(mismatch), 32'(r.mm));
        check_val("err", 32'(err), 32'(r.e));
        check_val("cnt", 32'(cnt), 32'(r.c));
        check_val("expected", 32'(expected), 32'(r.x));
      end
    end else if (rst) begin
      check_val("no_beat_no_pulse", 32'({match, mismatch}), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, t;
    model_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_match", 32'(match), 32'd0);
    check_val("rst_mismatch", 32'(mismatch), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_cnt", 32'(cnt), 32'd0);
    check_val("rst_expected", 32'(expected), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;

`ifndef FIB_CHECK_DOUBLE_RATE_EN
    // Basic run 1,1,2,3,5,8
    send(1); send(1); send(2); send(3); send(5); send(8);
    idle();
    #1;
    check_val("run6_cnt", 32'(cnt), 32'd6);
    check_val("run6_expected", 32'(expected), 32'd13);
    check_val("run6_err", 32'(err), 32'd0);

    // clr wins over a simultaneous beat
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_num = 16'd13;
    model_reset();
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    #1;
    check_val("clr_beat_cnt", 32'(cnt), 32'd0);
    check_val("clr_beat_expected", 32'(expected), 32'd0);

    // Mismatch on 1,1,2,4, fail state ignores beats, clr recovers
    send(1); send(1); send(2); send(4);
    idle();
    #1;
    check_val("fail_err", 32'(err), 32'd1);
    check_val("fail_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b1; in_num = 16'd5;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("fail_cnt_hold", 32'(cnt), 32'd3);
    check_val("fail_expected_frozen", 32'(expected), 32'd3);
    pulse_clr();
    check_val("clr_in_ready", 32'(in_ready), 32'd1);
    check_val("clr_cnt", 32'(cnt), 32'd0);
    check_val("clr_err", 32'(err), 32'd0);

    // 25 terms with wrap-around at term 25
    a = 0; b = 1;
    for (int k = 1; k <= 25; k++) begin
      send(b);
      if (k == 24) begin
        #1;
        check_val("wrap_expected_t25", 32'(expected), 32'd9489);
      end
      t = a + b; a = b; b = t;
    end
    idle();
    #1;
    check_val("wrap_cnt", 32'(cnt), 32'd25);
    check_val("wrap_err", 32'(err), 32'd0);
    check_val("wrap_expected_t26", 32'(expected), 32'd55857);
    pulse_clr();

    // Bad first seed
    send(2);
    idle();
    #1;
    check_val("seed_err", 32'(err), 32'd1);
    pulse_clr();

    // Asynchronous reset mid-stream with in_valid held
    send(1); send(1); send(2);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_val("arst_match", 32'(match), 32'd0);
    check_val("arst_cnt", 32'(cnt), 32'd0);
    check_val("arst_expected", 32'(expected), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    send(1); send(1);
    idle();
    #1;
    check_val("arst_reseed_cnt", 32'(cnt), 32'd2);

    // SEED_CHECK=0 instance, 3-bit counter saturating at 7
    begin
      logic [W-1:0] seq0 [9];
      seq0 = '{16'd2, 16'd7, 16'd9, 16'd16, 16'd25, 16'd41, 16'd66, 16'd107, 16'd173};
      for (int i = 0; i < 9; i++) begin
        send0(seq0[i]);
        check_val("d0_match", 32'(match0), 32'd1);
        check_val("d0_cnt", 32'(cnt0), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        if (i == 1) check_val("d0_seed_expected", 32'(expected0), 32'd9);
      end
      check_val("d0_err", 32'(err0), 32'd0);
      send0(16'd100);
      check_val("d0_mismatch", 32'(mismatch0), 32'd1);
      check_val("d0_bad_err", 32'(err0), 32'd1);
      check_val("d0_in_ready", 32'(in_ready0), 32'd0);
      @(negedge clk);
      in_valid0 = 1'b0;
    end
`else
    // Two terms per beat
    send_pair(1, 1); send_pair(2, 3); send_pair(5, 8);
    idle();
    #1;
    check_val("pair_cnt", 32'(cnt), 32'd6);
    check_val("pair_expected", 32'(expected), 32'd13);
    send_pair(13, 20);
    idle();
    #1;
    check_val("pair_err", 32'(err), 32'd1);
    check_val("pair_fail_cnt", 32'(cnt), 32'd6);
    check_val("pair_in_ready", 32'(in_ready), 32'd0);
    pulse_clr();
    check_val("pair_clr_cnt", 32'(cnt), 32'd0);
    check_val("pair_clr_err", 32'(err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
